barrel_shifter32: RTL and testbench
===================================

BARREL_SHIFTER32 -- requirements
Module: barrel_shifter32

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits; WIDTH SHALL be a power of two, at least 2.
REQ-002 Derived SHAMT_W = log2(WIDTH), which is 5 for the default; it SHALL size shift_amount.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset; synchronous and active-low.
REQ-005 data_in  input  WIDTH  operand to be shifted.
REQ-006 shift_amount  input  SHAMT_W  unsigned shift distance, 0 to WIDTH-1.
REQ-007 direction  input  1  0 = logical left shift, 1 = logical right shift.
REQ-008 data_out  output  WIDTH  registered shift result.

Function
REQ-009 The block SHALL compute a logical shift only: vacated bit positions are filled with 0, with no sign extension and no rotation.
REQ-010 Left shift (direction=0): result = data_in << shift_amount, truncated to WIDTH bits; bits shifted past the MSB are discarded.
REQ-011 Right shift (direction=1): result = data_in >> shift_amount; bits shifted past the LSB are discarded.
REQ-012 Shift logic SHALL be a log-structured barrel network of SHAMT_W mux stages.
- Stage k shifts by 2^k when shift_amount[k]=1, otherwise passes its input unchanged.
- There SHALL be no iterative or multi-cycle shifting.
REQ-013 Direction handling SHALL use one of two methods, both bit-exact to REQ-010/011:
- bit-reverse data_in before the network and bit-reverse the network output after it, using a single right-shift network; or
- two parallel networks followed by a final select.
REQ-014 The combinational result SHALL be captured into data_out on every rising clk edge when rst_n=1; there is no enable.
REQ-015 Latency SHALL be exactly 1 cycle: inputs sampled at edge N appear on data_out after edge N and are held until edge N+1.
REQ-016 Throughput SHALL be one new operation per cycle; back-to-back changes to any input SHALL each produce their own result on the following cycle.
REQ-017 shift_amount=0 SHALL pass data_in unchanged in both directions.
REQ-018 shift_amount=WIDTH-1:
- left: result = data_in[0] placed at the MSB, all other bits 0;
- right: result = data_in[WIDTH-1] placed at the LSB, all other bits 0.
REQ-019 data_in=0 SHALL yield 0 for every shift_amount and direction.
REQ-020 No X propagation is permitted; every data_out bit SHALL be driven from a defined register.

Reset
REQ-021 When rst_n=0 at a rising clk edge, data_out SHALL become all-zero on that edge.
REQ-022 Reset SHALL take priority over the shift result on the same edge.
REQ-023 Reset asserted mid-stream SHALL discard the in-flight result; no stale value may appear after reset is released.
REQ-024 The first edge with rst_n=1 after reset SHALL capture the result of the inputs present at that edge.
REQ-025 rst_n SHALL have no asynchronous effect: data_out SHALL not change between clock edges.

Verification
REQ-026 Reset check: hold rst_n=0 for 2 edges with data_in=32'hFFFFFFFF -> data_out=0; release -> next edge data_out=32'hFFFFFFFF when shift_amount=0.
REQ-027 Left shifts with direction=0 and data_in=32'h1:
- shift_amount=0 -> 32'h00000001;
- shift_amount=1 -> 32'h00000002;
- shift_amount=31 -> 32'h80000000;
- each result appears one cycle after it is applied.
REQ-028 Right shifts with direction=1:
- data_in=32'h4, shift_amount=1 -> 32'h00000002;
- data_in=32'h80000000, shift_amount=31 -> 32'h00000001 (zero fill, no sign extension).
REQ-029 Discard and zero fill:
- data_in=32'hF0000000, direction=0, shift_amount=4 -> 0;
- data_in=32'h0000000F, direction=1, shift_amount=4 -> 0.
REQ-030 Stream and random checks:
- change inputs every cycle for 16 cycles -> each data_out equals the reference shift of the previous cycle's inputs;
- run 1000 random vectors with a golden-model compare covering both directions and all 32 amounts.
REQ-031 Mid-stream reset: pulse rst_n=0 for one edge during the stream -> data_out=0 on that edge; the following cycle resumes correct results.

Source files
------------

// File: rtl/barrel_shifter32_if.sv
// barrel_shifter32_if -- operand/result bundle for the registered barrel shifter.
//   data_in      : operand to be shifted (WIDTH bits)
//   shift_amount : unsigned shift distance, 0 to WIDTH-1 (log2(WIDTH) bits)
//   direction    : 0 = logical left, 1 = logical right
//   data_out     : registered shift result (WIDTH bits)
// The master modport drives the operands; the slave modport is the shifter.
interface barrel_shifter32_if #(
  parameter int WIDTH = 32
);
  localparam int SHAMT_W = $clog2(WIDTH);

  logic [WIDTH-1:0]   data_in;
  logic [SHAMT_W-1:0] shift_amount;
  logic               direction;
  logic [WIDTH-1:0]   data_out;

  modport master (
    output data_in,
    output shift_amount,
    output direction,
    input  data_out
  );

  modport slave (
    input  data_in,
    input  shift_amount,
    input  direction,
    output data_out
  );
endinterface

// File: rtl/barrel_shifter32.sv
// barrel_shifter32 -- single-cycle logical barrel shifter with a registered output.
//   clk   : sole clock, all state on the rising edge
//   rst_n : synchronous active-low reset, clears data_out
//   bus   : barrel_shifter32_if slave (data_in, shift_amount, direction in; data_out out)
// One new operation is accepted every cycle; the result appears one cycle later.
module barrel_shifter32 #(
  parameter int WIDTH = 32
) (
  input logic                clk,
  input logic                rst_n,
  barrel_shifter32_if.slave  bus
);
  localparam int SHAMT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] net_in;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] stage [0:SHAMT_W];
  logic [WIDTH-1:0] data_q;

  // Only a right-shift network is built. A left shift is done by reversing
  // the bit order on the way in and again on the way out, which turns
  // (x << s) into rev(rev(x) >> s) with identical zero fill.
  for (genvar i = 0; i < WIDTH; i++) begin : g_rev
    assign net_in[i] = bus.direction ? bus.data_in[i] : bus.data_in[WIDTH-1-i];
    assign result[i] = bus.direction ? stage[SHAMT_W][i] : stage[SHAMT_W][WIDTH-1-i];
  end

  // Log-structured network: stage k shifts by 2^k when shift_amount[k] is set.
  assign stage[0] = net_in;
  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    assign stage[k+1] = bus.shift_amount[k] ? (stage[k] >> (1 << k)) : stage[k];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= result;
    end
  end

  assign bus.data_out = data_q;
endmodule

// File: tb/tb_barrel_shifter32.sv
// tb_barrel_shifter32 -- scoreboard bench for barrel_shifter32.
// Each applied vector pushes its expected registered result; after the next
// rising edge the scenario task pops it and compares against data_out.
module tb_barrel_shifter32;
  logic clk;
  logic rst_n;

  barrel_shifter32_if #(.WIDTH(32)) bus ();

  barrel_shifter32 #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests_run = 0;
  int fails     = 0;
  logic [31:0] sb [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] amt,
                                            input logic dir);
    return dir ? (d >> amt) : (d << amt);
  endfunction

  // Called #1 after a rising edge: sets the inputs, records the expected
  // output for the coming edge, and returns #1 after that edge.
  task automatic drive(input logic [31:0] d, input logic [4:0] amt, input logic dir,
                       input logic rst_v);
    bus.data_in      = d;
    bus.shift_amount = amt;
    bus.direction    = dir;
    rst_n            = rst_v;
    sb.push_back(rst_v ? ref_shift(d, amt, dir) : 32'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    drive(32'hFFFF_FFFF, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      if (i == 1) drive(32'hFFFF_FFFF, 5'd0, 1'b0, 1'b0);
      exp = sb.pop_front();
      tests_run++;
      if (bus.data_out !== exp) begin
        fails++;
        $display("FAIL reset_hold%0d: got %h expected %h", i, bus.data_out, exp);
      end
    end
    drive(32'hFFFF_FFFF, 5'd0, 1'b0, 1'b1);
    exp = sb.pop_front();
    tests_run++;
    if (bus.data_out !== exp) begin
      fails++;
      $display("FAIL reset_release: got %h expected %h", bus.data_out, exp);
    end
    // Reset dropped between edges must not touch data_out until the next edge.
    rst_n = 1'b0;
    #2;
    tests_run++;
    if (bus.data_out !== 32'hFFFF_FFFF) begin
      fails++;
      $display("FAIL reset_no_async: got %h expected %h", bus.data_out, 32'hFFFF_FFFF);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.data_out !== 32'h0) begin
      fails++;
      $display("FAIL reset_sync_edge: got %h expected %h", bus.data_out, 32'h0);
    end
  endtask

  task automatic test_directed();
    logic [31:0] d_v [10] = '{32'h1, 32'h1, 32'h1, 32'h4, 32'h8000_0000,
                              32'hF000_0000, 32'h0000_000F, 32'hA5A5_1234,
                              32'hA5A5_1234, 32'h0};
    logic [4:0]  a_v [10] = '{5'd0, 5'd1, 5'd31, 5'd1, 5'd31, 5'd4, 5'd4,
                              5'd0, 5'd31, 5'd17};
    logic        r_v [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                              1'b1, 1'b1, 1'b1};
    logic [31:0] e_v [10] = '{32'h1, 32'h2, 32'h8000_0000, 32'h2, 32'h1,
                              32'h0, 32'h0, 32'hA5A5_1234, 32'h1, 32'h0};
    logic [31:0] exp;
    for (int i = 0; i < 10; i++) begin
      drive(d_v[i], a_v[i], r_v[i], 1'b1);
      exp = sb.pop_front();
      tests_run++;
      if (bus.data_out !== e_v[i] || bus.data_out !== exp) begin
        fails++;
        $display("FAIL directed%0d: got %h expected %h", i, bus.data_out, e_v[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    for (int i = 0; i < 16; i++) begin
      drive($urandom, 5'($urandom_range(0, 31)), 1'(i % 2), 1'b1);
      exp = sb.pop_front();
      tests_run++;
      if (bus.data_out !== exp) begin
        fails++;
        $display("FAIL stream%0d: got %h expected %h", i, bus.data_out, exp);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] exp;
    for (int i = 0; i < 6; i++) begin
      drive(32'hDEAD_BEEF ^ i, 5'(i * 3), 1'(i % 2), (i == 3) ? 1'b0 : 1'b1);
      exp = sb.pop_front();
      tests_run++;
      if (bus.data_out !== exp) begin
        fails++;
        $display("FAIL midreset%0d: got %h expected %h", i, bus.data_out, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] exp;
    logic [31:0] d;
    for (int i = 0; i < 1000; i++) begin
      d = (i % 97 == 0) ? 32'h0 : $urandom;
      drive(d, 5'(i % 32), 1'((i / 32) % 2), 1'b1);
      exp = sb.pop_front();
      tests_run++;
      if (bus.data_out !== exp) begin
        fails++;
        $display("FAIL random%0d: got %h expected %h", i, bus.data_out, exp);
      end
    end
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.data_in      = '0;
    bus.shift_amount = '0;
    bus.direction    = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_mid_reset();
    test_random();
    tests_run++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d expected %0d", sb.size(), 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
